// File: rtl/vram_pkg.sv
// Shared widths, requester IDs and read-tag layout for the VRAM port-A arbiter.
package vram_pkg;

  localparam int VRAM_AW = 15;
  localparam int VRAM_DW = 16;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  typedef struct packed {
    logic valid;
    logic dest;
    logic err;
  } rd_tag_t;

  localparam int TAG_W = $bits(rd_tag_t);

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// DEPTH-deep shift register that carries a read tag alongside the RAM read latency.
module vram_rd_tag_pipe
  import vram_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W-1:0] tag_o
);

  logic [TAG_W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares VRAM port A between the CPU core and the DMA engine: core priority with a
// starvation guard, and tagged read returns routed back to the issuing requester.
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int RAM_AW       = VRAM_AW,
  parameter int DATA_W       = VRAM_DW,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              addr_err
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              dma_prio_q, dma_prio_d;
  logic              addr_err_q, addr_err_d;
  logic              dma_sel, any_gnt, sel_we, sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [TAG_W-1:0]  tag_out_w;
  rd_tag_t           tag_in, tag_out;

  // Grant and RAM mux are combinational so an accepted request reaches the RAM this cycle.
  always_comb begin
    dma_sel   = dma_req && (!core_req || dma_prio_q);
    core_gnt  = rst_n && core_req && !dma_sel;
    dma_gnt   = rst_n && dma_sel;
    any_gnt   = core_gnt || dma_gnt;
    sel_addr  = dma_sel ? dma_addr : core_addr;
    sel_we    = dma_sel ? dma_we : core_we;
    sel_oor   = |sel_addr[ADDR_W-1:RAM_AW];
    ram_addr  = rst_n ? sel_addr[RAM_AW-1:0] : '0;
    ram_we    = any_gnt && sel_we && !sel_oor;
    ram_wdata = dma_sel ? dma_wdata : core_wdata;

    tag_in.valid = any_gnt && !sel_we;
    tag_in.dest  = dma_gnt ? REQ_DMA : REQ_CORE;
    tag_in.err   = sel_oor;
    addr_err_d   = any_gnt && sel_oor;
  end

  // Counts core wins while DMA waits; reaching the limit hands DMA the next grant.
  always_comb begin
    starve_d   = starve_q;
    dma_prio_d = dma_prio_q;
    if (dma_gnt || !dma_req) begin
      starve_d = '0;
    end else if (core_gnt && starve_q != LIMIT) begin
      starve_d = starve_q + 1'b1;
    end
    if (dma_gnt) begin
      dma_prio_d = 1'b0;
    end else if (starve_d == LIMIT) begin
      dma_prio_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q   <= '0;
      dma_prio_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      dma_prio_q <= dma_prio_d;
      addr_err_q <= addr_err_d;
    end
  end

  vram_rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .clr_i (!rst_n),
    .tag_i (tag_in),
    .tag_o (tag_out_w)
  );

  assign tag_out = rd_tag_t'(tag_out_w);

  // Out-of-range reads still return on time, but with zero data.
  always_comb begin
    core_rvalid = rst_n && tag_out.valid && (tag_out.dest == REQ_CORE);
    dma_rvalid  = rst_n && tag_out.valid && (tag_out.dest == REQ_DMA);
    core_rdata  = (core_rvalid && !tag_out.err) ? ram_rdata : '0;
    dma_rdata   = (dma_rvalid && !tag_out.err) ? ram_rdata : '0;
  end

  assign addr_err = rst_n && addr_err_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Randomised and directed bench for vram_port_arbiter with a behavioural RAM and scoreboard.
module tb_vram_port_arbiter;

  localparam int LAT   = 1;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, dma_req, dma_we;
  logic [23:0] core_addr, dma_addr;
  logic [15:0] core_wdata, dma_wdata;
  logic        core_gnt, core_rvalid, dma_gnt, dma_rvalid;
  logic [15:0] core_rdata, dma_rdata;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        addr_err;

  always #5 clk = ~clk;

  vram_port_arbiter #(
    .ADDR_W(24), .RAM_AW(15), .DATA_W(16), .RD_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .addr_err(addr_err)
  );

  typedef struct {
    logic        dest;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];
  logic        mem_ready = 1'b0;
  logic        cg, dg, crv, drv, rwe, aerr;
  logic [15:0] crd, drd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] init_val(input int a);
    case (a)
      0:       return 16'h1234;
      'h10:    return 16'hBEEF;
      'h20:    return 16'h1111;
      'h21:    return 16'h2222;
      default: return 16'(a * 40503 + 17);
    endcase
  endfunction

  function automatic logic [23:0] rnd_addr();
    int x = $urandom_range(0, 19);
    if (x == 0) return {9'($urandom_range(1, 511)), 15'($urandom)};
    if (x < 10) return 24'(x);
    return 24'h7FF0 + 24'(x - 10);
  endfunction

  // Behavioural port-A RAM, read latency of one cycle.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32768; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Issue side: reference arbitration model, RAM drive checks, expected reads pushed.
  initial begin
    int          streak;
    logic        exp_err, ec, ed, we, oor, gnt;
    logic [23:0] a;
    logic [15:0] wd;
    streak  = 0;
    exp_err = 1'b0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_core_gnt", 32'(core_gnt), 32'(0));
        chk("rst_dma_gnt", 32'(dma_gnt), 32'(0));
        chk("rst_ram_we", 32'(ram_we), 32'(0));
        chk("rst_ram_addr", 32'(ram_addr), 32'(0));
        chk("rst_addr_err", 32'(addr_err), 32'(0));
        streak  = 0;
        exp_err = 1'b0;
      end else begin
        chk("addr_err", 32'(addr_err), 32'(exp_err));
        ed  = dma_req && (!core_req || streak >= LIMIT);
        ec  = core_req && !ed;
        gnt = ec || ed;
        chk("core_gnt", 32'(core_gnt), 32'(ec));
        chk("dma_gnt", 32'(dma_gnt), 32'(ed));
        a   = ed ? dma_addr : core_addr;
        we  = ed ? dma_we : core_we;
        wd  = ed ? dma_wdata : core_wdata;
        oor = (a >= 24'h008000);
        chk("ram_we", 32'(ram_we), 32'(gnt && we && !oor));
        chk("ram_addr", 32'(ram_addr), 32'(a[14:0]));
        if (gnt && we && !oor) begin
          chk("ram_wdata", 32'(ram_wdata), 32'(wd));
          ref_mem[a[14:0]] = wd;
        end
        if (gnt && !we) sb.push_back('{ed, oor ? 16'h0000 : ref_mem[a[14:0]], cyc});
        exp_err = gnt && oor;
        if (ed) streak = 0;
        else if (dma_req && ec) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
        else if (!dma_req) streak = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_rvalid", 32'({dma_rvalid, core_rvalid}), 32'(0));
        chk("rst_rdata", {core_rdata, dma_rdata}, 32'(0));
        sb.delete();
      end else if (core_rvalid || dma_rvalid) begin
        chk("one_rvalid", 32'(core_rvalid && dma_rvalid), 32'(0));
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 32'({dma_rvalid, core_rvalid}), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("rd_latency", 32'(cyc - e.cyc), 32'(LAT));
          chk("rd_dest", 32'({dma_rvalid, core_rvalid}), e.dest ? 32'(2) : 32'(1));
          chk("rd_data", 32'(e.dest ? dma_rdata : core_rdata), 32'(e.data));
          chk("other_rdata", 32'(e.dest ? core_rdata : dma_rdata), 32'(0));
        end
      end else begin
        chk("idle_rdata", {core_rdata, dma_rdata}, 32'(0));
        if (sb.size() != 0 && cyc - sb[0].cyc >= LAT) begin
          e = sb.pop_front();
          chk("missing_rvalid", 32'({dma_rvalid, core_rvalid}), e.dest ? 32'(2) : 32'(1));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
    cg   = core_gnt;
    dg   = dma_gnt;
    crv  = core_rvalid;
    drv  = dma_rvalid;
    crd  = core_rdata;
    drd  = dma_rdata;
    rwe  = ram_we;
    aerr = addr_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gseq[10];
    int expseq[10];
    expseq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    rst_n = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 24'h10; core_wdata = '0;
    dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 24'h20; dma_wdata  = '0;
    repeat (3) step();
    chk("rst_grants", 32'({cg, dg}), 32'(0));
    rst_n = 1'b1; core_req = 1'b0; dma_req = 1'b0;
    step();

    // Core-only read
    core_req = 1'b1; core_we = 1'b0; core_addr = 24'h000010;
    step(); chk("t1_core_gnt", 32'(cg), 32'(1));
    core_req = 1'b0;
    step();
    chk("t1_rvalid", 32'(crv), 32'(1));
    chk("t1_rdata", 32'(crd), 32'(16'hBEEF));
    chk("t1_dma_rvalid", 32'(drv), 32'(0));

    // Interleaved DMA then core reads
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 24'h20;
    step(); chk("il_dma_gnt", 32'(dg), 32'(1));
    dma_req = 1'b0; core_req = 1'b1; core_we = 1'b0; core_addr = 24'h21;
    step(); chk("il_core_gnt", 32'(cg), 32'(1));
    chk("il_dma_data", 32'({drv, drd}), 32'({1'b1, 16'h1111}));
    core_req = 1'b0;
    step(); chk("il_core_data", 32'({crv, crd}), 32'({1'b1, 16'h2222}));

    // Continuous contention
    core_req = 1'b1; dma_req = 1'b1; core_we = 1'b0; dma_we = 1'b0;
    core_addr = 24'($urandom_range(0, 32767)); dma_addr = 24'($urandom_range(0, 32767));
    for (int i = 0; i < 10; i++) begin
      step();
      gseq[i] = dg ? 1 : (cg ? 0 : 2);
      chk("cont_one_gnt", 32'(cg && dg), 32'(0));
      if (cg) core_addr = 24'($urandom_range(0, 32767));
      if (dg) dma_addr  = 24'($urandom_range(0, 32767));
    end
    for (int i = 0; i < 10; i++) chk("cont_seq", 32'(gseq[i]), 32'(expseq[i]));
    core_req = 1'b0; dma_req = 1'b0;
    step();

    // Out-of-range write and read
    core_req = 1'b1; core_we = 1'b1; core_addr = 24'h008000; core_wdata = 16'hAAAA;
    step(); chk("oor_gnt", 32'(cg), 32'(1)); chk("oor_ram_we", 32'(rwe), 32'(0));
    core_req = 1'b0; core_we = 1'b0;
    step(); chk("oor_addr_err", 32'(aerr), 32'(1));
    step(); chk("oor_addr_err_end", 32'(aerr), 32'(0));
    chk("oor_mem0", 32'(mem[0]), 32'(16'h1234));
    core_req = 1'b1; core_addr = 24'h008000;
    step(); chk("oor_rd_gnt", 32'(cg), 32'(1));
    core_req = 1'b0;
    step(); chk("oor_rd_data", 32'({crv, crd}), 32'({1'b1, 16'h0000}));

    // DMA write then core read of the top word
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 24'h007FFF; dma_wdata = 16'h5A5A;
    step(); chk("wr_dma_gnt", 32'(dg), 32'(1));
    dma_req = 1'b0; dma_we = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 24'h007FFF;
    step(); chk("wr_core_gnt", 32'(cg), 32'(1));
    core_req = 1'b0;
    step(); chk("wr_rd_data", 32'({crv, crd}), 32'({1'b1, 16'h5A5A}));

    // Reset while a read is in flight
    core_req = 1'b1; core_addr = 24'h10;
    step(); chk("mr_gnt", 32'(cg), 32'(1));
    rst_n = 1'b0; dma_req = 1'b1;
    step(); chk("mr_rst_gnts", 32'({cg, dg}), 32'(0)); chk("mr_rst_rvalid", 32'(crv), 32'(0));
    step(); chk("mr_rst_gnts2", 32'({cg, dg}), 32'(0));
    rst_n = 1'b1; core_req = 1'b0; dma_req = 1'b0;
    step(); chk("mr_after_rvalid", 32'({crv, drv}), 32'(0));
    step(); chk("mr_after_rvalid2", 32'({crv, drv}), 32'(0));

    // Random traffic; requesters hold their fields until granted
    for (int i = 0; i < 600; i++) begin
      if (!core_req || cg) begin
        if ($urandom_range(0, 3) != 0) begin
          core_req = 1'b1; core_we = 1'($urandom_range(0, 1));
          core_addr = rnd_addr(); core_wdata = 16'($urandom);
        end else begin
          core_req = 1'b0;
        end
      end
      if (!dma_req || dg) begin
        if ($urandom_range(0, 3) != 0) begin
          dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
          dma_addr = rnd_addr(); dma_wdata = 16'($urandom);
        end else begin
          dma_req = 1'b0;
        end
      end
      step();
    end
    core_req = 1'b0; dma_req = 1'b0;
    repeat (4) step();
    chk("drain", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
